// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter with a one-deep valid/ready output stage.
// Pixels arrive in raster order; each accepted pixel yields one result one
// cycle later, centred one row up and one column left of that pixel.
// Optional feature: define SOBEL_THRESHOLD_EN to binarise the magnitude
// against a button-adjustable threshold register.
module sobel_stream_filter #(
    parameter int PIXEL_W  = 15,
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int THR_INIT = 2**(PIXEL_W-1),
    parameter int THR_STEP = 2**(PIXEL_W-4)
) (
    input  logic               sobel_clk,
    input  logic               reset,
    input  logic               threshold_up,
    input  logic               threshold_down,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIXEL_W-1:0] input_px_gray,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PIXEL_W-1:0] output_px_sobel,
    output logic               frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int SW = PIXEL_W + 4;
    localparam logic [CW-1:0]      COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]      ROW_LAST = RW'(IMG_H - 1);
    localparam logic [PIXEL_W-1:0] PX_MAX   = '1;

    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic [PIXEL_W-1:0] line_a [IMG_W];   // previous line (row-1)
    logic [PIXEL_W-1:0] line_b [IMG_W];   // line before that (row-2)
    logic [PIXEL_W-1:0] win    [3][2];    // columns col-2 and col-1, top to bottom
    logic [PIXEL_W-1:0] col_tap [3];      // live column col, top to bottom
    logic signed [SW-1:0] px [3][3];
    logic signed [SW-1:0] gx, gy, abs_gx, abs_gy;
    logic [SW-1:0]        mag;
    logic [PIXEL_W-1:0]   mag_sat, result;
    logic                 xfer_in, last_px, border;

    function automatic logic signed [SW-1:0] ext(input logic [PIXEL_W-1:0] v);
        return $signed({4'b0000, v});
    endfunction

    assign in_ready = out_ready | ~out_valid;
    assign xfer_in  = in_valid & in_ready;
    assign last_px  = (col == COL_LAST) && (row == ROW_LAST);
    assign border   = (row < RW'(2)) || (col < CW'(2));

`ifdef SOBEL_THRESHOLD_EN
    logic               up_q, down_q, up_rise, down_rise;
    logic [PIXEL_W-1:0] thr;
    logic [PIXEL_W:0]   thr_sum;
    localparam logic [PIXEL_W:0] STEP = (PIXEL_W+1)'(THR_STEP);

    assign up_rise   = threshold_up & ~up_q;
    assign down_rise = threshold_down & ~down_q;
    assign thr_sum   = {1'b0, thr} + STEP;

    // Threshold register driven by rising edges of the two buttons.
    always_ff @(posedge sobel_clk) begin
        if (reset) begin
            up_q   <= 1'b0;
            down_q <= 1'b0;
            thr    <= PIXEL_W'(THR_INIT);
        end else begin
            up_q   <= threshold_up;
            down_q <= threshold_down;
            if (up_rise && !down_rise)
                thr <= (thr_sum > {1'b0, PX_MAX}) ? PX_MAX : thr_sum[PIXEL_W-1:0];
            else if (down_rise && !up_rise)
                thr <= ({1'b0, thr} < STEP) ? '0 : thr - STEP[PIXEL_W-1:0];
        end
    end
`else
    logic unused_buttons;
    assign unused_buttons = threshold_up ^ threshold_down ^ 1'(THR_INIT) ^ 1'(THR_STEP);
`endif

    // Sobel kernels over the two registered columns plus the live column.
    // NOTE: every variable here gets a value on every path, so no latch is inferred.
    always_comb begin
        col_tap[0] = line_b[col];
        col_tap[1] = line_a[col];
        col_tap[2] = input_px_gray;
        for (int r = 0; r < 3; r++) begin
            px[r][0] = ext(win[r][0]);
            px[r][1] = ext(win[r][1]);
            px[r][2] = ext(col_tap[r]);
        end
        gx = (px[0][2] + px[1][2] + px[1][2] + px[2][2])
           - (px[0][0] + px[1][0] + px[1][0] + px[2][0]);
        gy = (px[2][0] + px[2][1] + px[2][1] + px[2][2])
           - (px[0][0] + px[0][1] + px[0][1] + px[0][2]);
        abs_gx  = gx[SW-1] ? -gx : gx;
        abs_gy  = gy[SW-1] ? -gy : gy;
        mag     = $unsigned(abs_gx) + $unsigned(abs_gy);
        mag_sat = (mag > {4'b0000, PX_MAX}) ? PX_MAX : mag[PIXEL_W-1:0];
`ifdef SOBEL_THRESHOLD_EN
        result  = (mag_sat >= thr) ? PX_MAX : '0;
`else
        result  = mag_sat;
`endif
        if (border)
            result = '0;
    end

    // Output stage and raster position; both move only on input transfers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sobel_clk) begin
        if (reset) begin
            out_valid       <= 1'b0;
            output_px_sobel <= '0;
            frame_done      <= 1'b0;
            col             <= '0;
            row             <= '0;
        end else begin
            frame_done <= xfer_in && last_px;
            if (xfer_in) begin
                output_px_sobel <= result;
                out_valid       <= 1'b1;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Line buffers and window shift on each accepted pixel.
    // NOTE: storage is deliberately not reset; the border rule masks stale contents.
    always_ff @(posedge sobel_clk) begin
        if (xfer_in && !reset) begin
            line_b[col] <= line_a[col];
            line_a[col] <= input_px_gray;
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= col_tap[r];
            end
        end
    end
endmodule
